// File: rtl/risc6_pkg.sv
// Shared opcode constants, fetch FSM state type and decode helper
// for the risc6 fetch controller.
package risc6_pkg;

  localparam logic [5:0] OP_LDI = 6'b000000;
  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_SUB = 6'b000010;
  localparam logic [5:0] OP_AND = 6'b000011;
  localparam logic [5:0] OP_STR = 6'b000111;
  localparam logic [5:0] OP_HLT = 6'b111111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_HALTED,
    S_ERROR
  } state_t;

  function automatic logic is_hlt(input logic [5:0] op);
    return op == OP_HLT;
  endfunction

endpackage

// File: rtl/risc6_ibuf.sv
// Prefetch buffer: synchronous FIFO with flush and occupancy count.
// Simultaneous push and pop both take effect.
module risc6_ibuf #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   C_ONE   = 1;
  localparam logic [AW:0]   C_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] P_ONE   = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          full, do_push, do_pop;

  assign empty   = count == '0;
  assign full    = count == C_FULL;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + P_ONE;
      if (do_pop)  rp <= rp + P_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/risc6_fetch_ctrl.sv
// risc6 fetch controller: prefetches words into risc6_ibuf, issues one per cycle.
// Define RISC6_STEP_EN to add step_mode/step single-step issue gating.
module risc6_fetch_ctrl
  import risc6_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic [31:0] core_pc,
  input  logic        core_halt,
  output logic [31:0] core_instr,
  output logic        core_en,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [15:0] issued_cnt
`ifdef RISC6_STEP_EN
  ,
  input  logic        step_mode,
  input  logic        step
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [AW:0]   C_ONE  = 1;
  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] T_ONE  = 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state;
  logic [31:0]   fetch_addr, last_instr, head;
  logic [TW-1:0] wait_cnt;
  logic [AW:0]   count, cnt_after;
  logic          empty, run, issue, stop, ack_ok, push;
  logic          raise, timeout, start_ok, flush, step_ok;

  assign run      = state == S_RUN;
  assign issue    = run & ~empty & ~core_halt & step_ok;
  assign stop     = run & (core_halt | (issue & is_hlt(head[31:26])));
  assign ack_ok   = imem_req & imem_ack;
  assign push     = run & ack_ok & ~stop;
  assign timeout  = imem_req & ~imem_ack & (wait_cnt == T_LAST);
  assign start_ok = start & (state == S_IDLE | state == S_HALTED |
                             state == S_ERROR);
  assign flush    = start_ok | stop;

  // occupancy after this edge, so a request can follow an ack directly
  always_comb begin
    cnt_after = count;
    if (push)  cnt_after = cnt_after + C_ONE;
    if (issue) cnt_after = cnt_after - C_ONE;
  end

  assign raise = run & ~stop & ~timeout & (~imem_req | imem_ack) &
                 (cnt_after < C_FULL);

  assign imem_addr  = fetch_addr;
  assign core_en    = issue;
  assign core_instr = issue ? head : last_instr;
  assign busy       = state == S_RUN | state == S_DRAIN;
  assign halted     = state == S_HALTED;
  assign err        = state == S_ERROR;

`ifdef RISC6_STEP_EN
  logic step_pend;
  assign step_ok = ~step_mode | step_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          step_pend <= 1'b0;
    else if (start_ok) step_pend <= 1'b0;
    else if (step)     step_pend <= 1'b1;
    else if (issue)    step_pend <= 1'b0;
  end
`else
  assign step_ok = 1'b1;
`endif

  risc6_ibuf #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   (imem_rdata),
    .pop   (issue),
    .dout  (head),
    .count (count),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      imem_req   <= 1'b0;
      fetch_addr <= '0;
      last_instr <= '0;
      wait_cnt   <= '0;
      issued_cnt <= '0;
    end else begin
      if (issue) last_instr <= head;
      if (issue && issued_cnt != 16'hFFFF)
        issued_cnt <= issued_cnt + 16'd1;
      if (ack_ok) fetch_addr <= fetch_addr + 32'd1;
      if (imem_req && !imem_ack) wait_cnt <= wait_cnt + T_ONE;
      else                       wait_cnt <= '0;
      unique case (state)
        S_IDLE, S_HALTED, S_ERROR: begin
          if (start) begin
            state      <= S_RUN;
            fetch_addr <= core_pc;
            issued_cnt <= '0;
          end
        end
        S_RUN: begin
          if (timeout) begin
            state    <= S_ERROR;
            imem_req <= 1'b0;
          end else if (stop) begin
            state    <= S_DRAIN;
            imem_req <= imem_req & ~imem_ack;
          end else begin
            imem_req <= raise | (imem_req & ~imem_ack);
          end
        end
        S_DRAIN: begin
          if (timeout) begin
            state    <= S_ERROR;
            imem_req <= 1'b0;
          end else if (!imem_req || imem_ack) begin
            state    <= S_HALTED;
            imem_req <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_risc6_fetch_ctrl.sv
// Bench for risc6_fetch_ctrl: randomized programs against an instruction-stream model,
// plus directed halt, timeout, reset and (with RISC6_STEP_EN) single-step scenarios.
module tb_risc6_fetch_ctrl;

  localparam logic [5:0]  HLT_OP = 6'b111111;
  localparam logic [31:0] JUNK   = 32'h0000_BEEF;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, core_halt = 1'b0;
  logic [31:0] core_pc = '0;
  logic        imem_req, imem_ack, core_en, busy, halted, err;
  logic [31:0] imem_addr, imem_rdata, core_instr;
  logic [15:0] issued_cnt;
  logic        resp_ack = 1'b0, man_ack = 1'b0;
  logic [31:0] resp_data = '0;
  int          lat = 1, hc = 0, cyc = 0, total = 0, bad = 0;
  bit          mem_on = 1'b0;
  logic [31:0] mem [bit [31:0]];
  logic [31:0] iss_q[$], ack_addr[$];
  int          iss_cyc[$], ack_cyc[$];
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
`ifdef RISC6_STEP_EN
  logic        step_mode = 1'b0, step = 1'b0;
`endif

  assign imem_ack   = resp_ack | man_ack;
  assign imem_rdata = resp_data;

  risc6_fetch_ctrl #(.DEPTH(2), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .core_pc(core_pc), .core_halt(core_halt),
    .core_instr(core_instr), .core_en(core_en),
    .busy(busy), .halted(halted), .err(err),
    .issued_cnt(issued_cnt)
`ifdef RISC6_STEP_EN
    , .step_mode(step_mode), .step(step)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd(input bit [31:0] a);
    if (mem.exists(a)) return mem[a];
    return JUNK;
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == HLT_OP) w[31] = 1'b0;
    return w;
  endfunction

  function automatic logic [31:0] iss_at(input int i);
    if (i >= 0 && i < iss_q.size()) return iss_q[i];
    return 'x;
  endfunction

  function automatic int cyc_at(input int i, input bit is_ack);
    if (is_ack) return (i < ack_cyc.size()) ? ack_cyc[i] : -1000;
    return (i < iss_cyc.size()) ? iss_cyc[i] : -1000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // memory: ack arrives lat cycles after the request first appears
  always begin
    @(posedge clk);
    #1;
    if (resp_ack || !imem_req) begin
      resp_ack = 1'b0;
      hc = 0;
    end
    if (imem_req && mem_on) begin
      hc++;
      if (hc > lat) begin
        resp_ack  = 1'b1;
        resp_data = rd(imem_addr);
      end
    end
  end

  always @(negedge clk) begin
    if (core_en) begin
      iss_q.push_back(core_instr);
      iss_cyc.push_back(cyc);
    end
    if (imem_req && imem_ack) begin
      ack_addr.push_back(imem_addr);
      ack_cyc.push_back(cyc);
    end
    if (prev_wait && imem_req && rst)
      check("addr_stable", imem_addr, prev_addr);
    prev_wait = imem_req & ~imem_ack;
    prev_addr = imem_addr;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_mon();
    iss_q.delete(); iss_cyc.delete();
    ack_addr.delete(); ack_cyc.delete();
  endtask

  task automatic do_start(input bit [31:0] pc);
    core_pc = pc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_halted(input int budget, input string tag);
    int n = 0;
    while (!halted && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 32'(halted), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   32'(imem_req),   0);
    check({tag, "_addr"},  imem_addr,       0);
    check({tag, "_en"},    32'(core_en),    0);
    check({tag, "_instr"}, core_instr,      0);
    check({tag, "_busy"},  32'(busy),       0);
    check({tag, "_halt"},  32'(halted),     0);
    check({tag, "_err"},   32'(err),        0);
    check({tag, "_cnt"},   32'(issued_cnt), 0);
  endtask

  task automatic load_rand(input bit [31:0] pc, input int n);
    mem.delete();
    for (int i = 0; i < n; i++) mem[pc + 32'(i)] = rnd_word();
    mem[pc + 32'(n)] = {HLT_OP, 26'($urandom)};
    for (int i = 1; i <= 4; i++) mem[pc + 32'(n + i)] = rnd_word();
  endtask

  // model: issued stream is memory from pc up to and including the first HLT
  task automatic run_check(input bit [31:0] pc, input int l,
                           input bit chk_gap, input string tag);
    logic [31:0] exp_q[$];
    logic [31:0] w;
    bit [31:0]   a;
    int          nb;
    a = pc;
    for (int i = 0; i < 64; i++) begin
      w = rd(a);
      exp_q.push_back(w);
      if (w[31:26] == HLT_OP) break;
      a = a + 1;
    end
    lat = l;
    mem_on = 1'b1;
    clear_mon();
    do_start(pc);
    wait_halted(3000, {tag, "_halted"});
    tick(4);
    check({tag, "_cnt"}, 32'(issued_cnt), 32'(exp_q.size()));
    check({tag, "_nissue"}, 32'(iss_q.size()), 32'(exp_q.size()));
    nb = 0;
    foreach (exp_q[i]) if (iss_at(i) !== exp_q[i]) nb++;
    check({tag, "_words"}, 32'(nb), 0);
    nb = 0;
    foreach (ack_addr[i]) if (ack_addr[i] !== pc + 32'(i)) nb++;
    check({tag, "_addrs"}, 32'(nb), 0);
    check({tag, "_lat"}, 32'(cyc_at(0, 1'b0) - cyc_at(0, 1'b1)), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(err), 0);
    if (chk_gap) begin
      nb = 0;
      for (int i = 1; i < iss_cyc.size(); i++)
        if (iss_cyc[i] - iss_cyc[i-1] != l + 1) nb++;
      check({tag, "_gap"}, 32'(nb), 0);
    end
  endtask

  initial begin
    bit [31:0] pc;
    int        n;
    tick(3);
    check_reset_vals("rst0");
    rst = 1'b1;
    tick(2);

    // LDI R0,2 / LDI R1,3 / ADD, stopped with core_halt
    mem.delete();
    mem[32'h10] = {6'b000000, 5'd0, 21'd2};
    mem[32'h11] = {6'b000000, 5'd1, 21'd3};
    mem[32'h12] = {6'b000001, 5'd2, 5'd0, 5'd1, 11'd0};
    lat = 1;
    mem_on = 1'b1;
    clear_mon();
    do_start(32'h10);
    n = 0;
    while (iss_q.size() < 3 && n < 100) begin
      tick(1);
      n++;
    end
    core_halt = 1'b1;
    tick(1);
    core_halt = 1'b0;
    wait_halted(100, "d1_halted");
    tick(3);
    check("d1_cnt", 32'(issued_cnt), 3);
    check("d1_nissue", 32'(iss_q.size()), 3);
    for (int i = 0; i < 3; i++) begin
      check("d1_word", iss_at(i), mem[32'h10 + 32'(i)]);
      check("d1_addr", (i < ack_addr.size()) ? ack_addr[i] : 'x,
            32'h10 + 32'(i));
    end

    // HLT as third word; fourth word must never issue
    mem.delete();
    mem[32'h20] = {6'b000000, 5'd0, 21'd2};
    mem[32'h21] = {6'b000000, 5'd1, 21'd3};
    mem[32'h22] = {HLT_OP, 26'd0};
    mem[32'h23] = {6'b000001, 5'd2, 5'd0, 5'd1, 11'd0};
    mem[32'h24] = {6'b000010, 26'd7};
    run_check(32'h20, 1, 1'b0, "hlt3");

    for (int k = 0; k < 4; k++) begin
      pc = $urandom;
      load_rand(pc, int'($urandom_range(1, 6)));
      run_check(pc, int'($urandom_range(1, 4)), 1'b0, "rnd");
    end
    load_rand(32'hFFFF_FFFE, 4);
    run_check(32'hFFFF_FFFE, 2, 1'b0, "wrap");
    pc = $urandom;
    load_rand(pc, 5);
    run_check(pc, 5, 1'b1, "lat5");

    // ack withheld until timeout, then restart from ERROR
    mem.delete();
    pc = $urandom;
    mem[pc] = {HLT_OP, 26'd5};
    mem_on = 1'b0;
    clear_mon();
    do_start(pc);
    n = 0;
    while (!imem_req && n < 20) begin
      tick(1);
      n++;
    end
    check("to_req_seen", 32'(imem_req), 1);
    n = 0;
    while (imem_req && n < 200) begin
      tick(1);
      n++;
    end
    check("to_cycles", 32'(n), 64);
    check("to_err", 32'(err), 1);
    check("to_busy", 32'(busy), 0);
    check("to_req", 32'(imem_req), 0);
    mem_on = 1'b1;
    do_start(pc);
    check("restart_err", 32'(err), 0);
    check("restart_busy", 32'(busy), 1);
    wait_halted(200, "restart_halted");
    check("restart_cnt", 32'(issued_cnt), 1);

    // reset while a request is pending, then a stray ack in IDLE
    pc = $urandom;
    load_rand(pc, 20);
    lat = 1;
    mem_on = 1'b1;
    clear_mon();
    do_start(pc);
    n = 0;
    while (iss_q.size() < 2 && n < 100) begin
      tick(1);
      n++;
    end
    mem_on = 1'b0;
    n = 0;
    while (!imem_req && n < 20) begin
      tick(1);
      n++;
    end
    check("rm_req_before", 32'(imem_req), 1);
    rst = 1'b0;
    #1;
    check_reset_vals("rm");
    tick(1);
    rst = 1'b1;
    tick(1);
    man_ack = 1'b1;
    tick(2);
    check("late_req", 32'(imem_req), 0);
    check("late_busy", 32'(busy), 0);
    check("late_en", 32'(core_en), 0);
    check("late_cnt", 32'(issued_cnt), 0);
    man_ack = 1'b0;
    tick(1);
    run_check(pc, 1, 1'b0, "post_rst");

`ifdef RISC6_STEP_EN
    begin
      int sc[3];
      pc = $urandom;
      load_rand(pc, 20);
      lat = 1;
      mem_on = 1'b1;
      step_mode = 1'b1;
      clear_mon();
      do_start(pc);
      tick(10);
      check("step_none", 32'(iss_q.size()), 0);
      for (int k = 0; k < 3; k++) begin
        step = 1'b1;
        sc[k] = cyc;
        tick(1);
        step = 1'b0;
        tick(9);
      end
      check("step_n", 32'(iss_q.size()), 3);
      for (int k = 0; k < 3; k++) begin
        check("step_cyc", 32'(cyc_at(k, 1'b0)), 32'(sc[k] + 1));
        check("step_word", iss_at(k), mem[pc + 32'(k)]);
      end
      step_mode = 1'b0;
      core_halt = 1'b1;
      tick(1);
      core_halt = 1'b0;
      wait_halted(100, "step_halted");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
